// File: rtl/rx_ack_generator_pkg.sv
// Shared flow-level widths, ACK packet type encoding and ACK generator state encoding.
// Imported by the receive-side ACK path and the window classifier users.
package rx_ack_generator_pkg;

  localparam int FLOW_SEQ_NUM_W  = 32;
  localparam int FLOW_TX_CNT_W   = 4;
  localparam int FLOW_WIN_SIZE   = 128;
  localparam int FLOW_PKT_TYPE_W = 4;

  localparam logic [FLOW_PKT_TYPE_W-1:0] ACK_PKT_TYPE = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADV  = 2'd1,
    SEND = 2'd2
  } rx_ack_state_e;

endpackage

// File: rtl/rx_seq_classify.sv
// Classifies a sequence number against a window base by modular difference: in window, old or ahead.
// Latency: combinational. Backpressure: none.
module rx_seq_classify #(
  parameter int SEQ_W    = 32,
  parameter int WIN_SIZE = 128,
  localparam int IDX_W   = $clog2(WIN_SIZE)
) (
  input  logic [SEQ_W-1:0] data_seq,
  input  logic [SEQ_W-1:0] cum,
  output logic             in_window,
  output logic             old,
  output logic             ahead,
  output logic [IDX_W-1:0] win_idx
);

  logic [SEQ_W-1:0] diff;

  // Unsigned wrap-around distance; the top half of the number space counts as behind the base.
  assign diff      = data_seq - cum;
  assign in_window = diff < SEQ_W'(WIN_SIZE);
  assign old       = diff[SEQ_W-1];
  assign ahead     = !in_window && !old;
  assign win_idx   = diff[IDX_W-1:0];

endmodule

// File: rtl/rx_ack_generator.sv
// Receive bitmap + cumulative ACK tracker emitting one ACK descriptor per accepted data packet.
// Latency: k+2 cycles in window (k = packets advanced), 1 cycle for old; one packet in flight, data_ready low until ACK handshake.
module rx_ack_generator
  import rx_ack_generator_pkg::*;
#(
  parameter int                    SEQ_W      = FLOW_SEQ_NUM_W,
  parameter int                    WIN_SIZE   = FLOW_WIN_SIZE,
  parameter int                    TX_CNT_W   = FLOW_TX_CNT_W,
  parameter int                    PKT_TYPE_W = FLOW_PKT_TYPE_W,
  parameter logic [PKT_TYPE_W-1:0] ACK_TYPE   = PKT_TYPE_W'(ACK_PKT_TYPE),
  parameter logic [SEQ_W-1:0]      INIT_SEQ   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [SEQ_W-1:0]      data_seq,
  input  logic [TX_CNT_W-1:0]   data_tx_id,
  output logic                  ack_valid,
  input  logic                  ack_ready,
  output logic [PKT_TYPE_W-1:0] ack_pkt_type,
  output logic [SEQ_W-1:0]      ack_cumulative,
  output logic [SEQ_W-1:0]      ack_selective,
  output logic [TX_CNT_W-1:0]   ack_tx_id,
  output logic                  ack_dup,
  output logic [15:0]           drop_cnt
);

  localparam int IDX_W = $clog2(WIN_SIZE);

  typedef struct packed {
    logic [SEQ_W-1:0]    cum;
    logic [SEQ_W-1:0]    sel;
    logic [TX_CNT_W-1:0] tx_id;
    logic                dup;
  } ack_t;

  rx_ack_state_e        state_q;
  rx_ack_state_e        state_d;
  logic                 live_q;
  logic [SEQ_W-1:0]     cum_q;
  logic [WIN_SIZE-1:0]  bitmap_q;
  logic [15:0]          drop_cnt_q;
  ack_t                 ack_q;

  logic                 data_hs;
  logic                 in_window;
  logic                 old;
  logic                 ahead;
  logic [IDX_W-1:0]     win_idx;

  rx_seq_classify #(
    .SEQ_W    (SEQ_W),
    .WIN_SIZE (WIN_SIZE)
  ) u_classify (
    .data_seq  (data_seq),
    .cum       (cum_q),
    .in_window (in_window),
    .old       (old),
    .ahead     (ahead),
    .win_idx   (win_idx)
  );

  // live_q keeps data_ready low while reset is held and for the first edge after release.
  assign data_ready     = live_q && (state_q == IDLE);
  assign data_hs        = data_valid && data_ready;
  assign ack_valid      = (state_q == SEND);
  assign ack_pkt_type   = ACK_TYPE;
  assign ack_cumulative = ack_q.cum;
  assign ack_selective  = ack_q.sel;
  assign ack_tx_id      = ack_q.tx_id;
  assign ack_dup        = ack_q.dup;
  assign drop_cnt       = drop_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_hs && in_window) begin
          state_d = ADV;
        end else if (data_hs && old) begin
          state_d = SEND;
        end
      end
      ADV: begin
        if (!bitmap_q[0]) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (ack_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= 1'b0;
      cum_q      <= INIT_SEQ;
      bitmap_q   <= '0;
      drop_cnt_q <= '0;
      ack_q      <= '0;
    end else begin
      live_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (data_hs && in_window) begin
            ack_q.dup         <= bitmap_q[win_idx];
            ack_q.sel         <= data_seq;
            ack_q.tx_id       <= data_tx_id;
            bitmap_q[win_idx] <= 1'b1;
          end else if (data_hs && old) begin
            ack_q.dup   <= 1'b1;
            ack_q.sel   <= data_seq;
            ack_q.tx_id <= data_tx_id;
            ack_q.cum   <= cum_q;
          end else if (data_hs && ahead && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end
        end
        ADV: begin
          // Bit 0 always tracks cum_q, so consume it and slide the window forward.
          if (bitmap_q[0]) begin
            bitmap_q <= bitmap_q >> 1;
            cum_q    <= cum_q + SEQ_W'(1);
          end else begin
            ack_q.cum <= cum_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ack_generator.sv
// Scoreboard bench for rx_ack_generator: two instances (INIT_SEQ 0 and 0xFFFFFFFE) driven with directed and random traffic.
// A set-based reference model predicts each ACK; a monitor pops and compares whenever ack_valid is shown.
module tb_rx_ack_generator;

  typedef struct {
    logic [31:0] cum;
    logic [31:0] sel;
    logic [3:0]  tx;
    logic        dup;
    int          exp_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        dv    [2];
  logic        dr    [2];
  logic [31:0] ds    [2];
  logic [3:0]  dt    [2];
  logic        av    [2];
  logic        ar    [2];
  logic [3:0]  apt   [2];
  logic [31:0] acum  [2];
  logic [31:0] asel  [2];
  logic [3:0]  atx   [2];
  logic        adup  [2];
  logic [15:0] dcnt  [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          bp_mode [2];
  bit          seen    [2];
  bit          orphan  [2];
  logic [31:0] last_cum [2];
  logic [31:0] m_cum   [2];
  logic [15:0] m_drop  [2];
  logic [31:0] init_seq [2];
  exp_t        exp_q [2][$];
  bit          got [logic [32:0]];

  rx_ack_generator #(.INIT_SEQ(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .data_valid(dv[0]), .data_ready(dr[0]), .data_seq(ds[0]),
    .data_tx_id(dt[0]), .ack_valid(av[0]), .ack_ready(ar[0]), .ack_pkt_type(apt[0]),
    .ack_cumulative(acum[0]), .ack_selective(asel[0]), .ack_tx_id(atx[0]), .ack_dup(adup[0]),
    .drop_cnt(dcnt[0])
  );

  rx_ack_generator #(.INIT_SEQ(32'hFFFF_FFFE)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .data_valid(dv[1]), .data_ready(dr[1]), .data_seq(ds[1]),
    .data_tx_id(dt[1]), .ack_valid(av[1]), .ack_ready(ar[1]), .ack_pkt_type(apt[1]),
    .ack_cumulative(acum[1]), .ack_selective(asel[1]), .ack_tx_id(atx[1]), .ack_dup(adup[1]),
    .drop_cnt(dcnt[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [95:0] act, logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the receiver's set of seen numbers; cum walks forward while the next number is in the set.
  task automatic model(int u, logic [31:0] seq, logic [3:0] tx, int h);
    logic [31:0] diff;
    exp_t        e;
    int          k;
    diff  = seq - m_cum[u];
    k     = 0;
    e.sel = seq;
    e.tx  = tx;
    if (diff < 32'd128) begin
      e.dup = got.exists({u[0], seq}) ? 1'b1 : 1'b0;
      got[{u[0], seq}] = 1'b1;
      while (got.exists({u[0], m_cum[u]})) begin
        got.delete({u[0], m_cum[u]});
        m_cum[u] = m_cum[u] + 32'd1;
        k++;
      end
      e.exp_cyc = h + k + 2;
    end else if (diff >= 32'h8000_0000) begin
      e.dup     = 1'b1;
      e.exp_cyc = h + 1;
    end else begin
      if (m_drop[u] != 16'hFFFF) m_drop[u] = m_drop[u] + 16'd1;
      return;
    end
    e.cum = m_cum[u];
    exp_q[u].push_back(e);
  endtask

  task automatic model_reset(int u);
    logic [32:0] k;
    logic [32:0] kill[$];
    if (got.first(k)) begin
      do begin
        if (k[32] == u[0]) kill.push_back(k);
      end while (got.next(k));
    end
    foreach (kill[i]) got.delete(kill[i]);
    exp_q[u].delete();
    seen[u]   = 1'b0;
    m_cum[u]  = init_seq[u];
    m_drop[u] = 16'd0;
  endtask

  task automatic send(int u, logic [31:0] seq, logic [3:0] tx);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    dv[u] = 1'b1;
    ds[u] = seq;
    dt[u] = tx;
    while (!ok && n < 3000) begin
      @(negedge clk);
      ok = dr[u];
      @(posedge clk); #1;
      n++;
    end
    dv[u] = 1'b0;
    if (!ok) check("send_timeout", 96'(0), 96'(1));
    else model(u, seq, tx, cyc);
  endtask

  task automatic drain(int u);
    int n;
    n = 0;
    while ((exp_q[u].size() != 0 || av[u]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 96'(exp_q[u].size()), 96'(0));
  endtask

  task automatic rand_phase(int u, int n);
    logic [31:0] off;
    int          r;
    bp_mode[u] = 1;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       off = 32'($urandom_range(0, 15));
      else if (r == 7) off = 32'(128 + $urandom_range(0, 5000));
      else             off = 32'(0) - 32'($urandom_range(1, 40));
      send(u, m_cum[u] + off, 4'($urandom_range(0, 15)));
    end
    bp_mode[u] = 0;
    drain(u);
    check("drop_cnt_random", 96'(dcnt[u]), 96'(m_drop[u]));
  endtask

  initial begin
    ar[0] = 1'b1;
    ar[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        if (bp_mode[u] == 0)      ar[u] = 1'b1;
        else if (bp_mode[u] == 1) ar[u] = ($urandom_range(0, 3) != 0);
        else                      ar[u] = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (!av[u]) begin
          orphan[u] = 1'b0;
        end else if (exp_q[u].size() == 0) begin
          if (!orphan[u]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack inst %0d: got ack sel=%h cum=%h expected none", u, asel[u], acum[u]);
          end
          orphan[u] = 1'b1;
        end else begin
          e = exp_q[u][0];
          if (!seen[u]) begin
            seen[u] = 1'b1;
            check("ack_latency", 96'(cyc + 1), 96'(e.exp_cyc));
          end
          check("ack_fields", {acum[u], asel[u], atx[u], adup[u], apt[u]},
                {e.cum, e.sel, e.tx, e.dup, 4'd1});
          check("ready_low_during_ack", 96'(dr[u]), 96'(0));
          if (ar[u]) begin
            void'(exp_q[u].pop_front());
            seen[u]     = 1'b0;
            last_cum[u] = acum[u];
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] base;
    int          rdy_bad;
    init_seq[0] = 32'h0000_0000;
    init_seq[1] = 32'hFFFF_FFFE;
    for (int u = 0; u < 2; u++) begin
      rst_n[u]   = 1'b0;
      dv[u]      = 1'b0;
      ds[u]      = '0;
      dt[u]      = '0;
      bp_mode[u] = 0;
      orphan[u]  = 1'b0;
      last_cum[u] = '0;
      model_reset(u);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_outputs", {av[u], dr[u], acum[u], asel[u], atx[u], adup[u], apt[u], dcnt[u]},
            {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 4'd1, 16'h0});
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // In order, then reorder 2,1,0, then old and duplicate.
    send(0, 32'd0, 4'd2);
    drain(0);
    check("inorder_cum", 96'(last_cum[0]), 96'(32'd1));
    send(0, 32'd3, 4'd5);
    send(0, 32'd2, 4'd6);
    send(0, 32'd1, 4'd7);
    drain(0);
    check("reorder_cum", 96'(last_cum[0]), 96'(32'd4));
    send(0, 32'd1, 4'd8);
    send(0, 32'd6, 4'd9);
    send(0, 32'd6, 4'd10);
    drain(0);
    check("dup_cum", 96'(last_cum[0]), 96'(32'd4));

    // One packet just past the window is dropped with no ACK and no stall.
    send(0, m_cum[0] + 32'd128, 4'd1);
    @(negedge clk);
    check("drop_ready", 96'(dr[0]), 96'(1));
    check("drop_cnt_one", 96'(dcnt[0]), 96'(m_drop[0]));
    drain(0);

    // Wrap-around with held ACKs on the second instance.
    bp_mode[1] = 2;
    send(1, 32'hFFFF_FFFE, 4'd3);
    repeat (10) @(negedge clk);
    check("held_valid", 96'(av[1]), 96'(1));
    bp_mode[1] = 0;
    drain(1);
    check("wrap_cum_a", 96'(last_cum[1]), 96'(32'hFFFF_FFFF));
    bp_mode[1] = 2;
    send(1, 32'hFFFF_FFFF, 4'd4);
    repeat (10) @(negedge clk);
    check("held_valid", 96'(av[1]), 96'(1));
    bp_mode[1] = 0;
    drain(1);
    check("wrap_cum_b", 96'(last_cum[1]), 96'(32'h0000_0000));

    rand_phase(1, 200);
    rand_phase(0, 200);

    // Fill 63 holes ahead of cum, then complete them so ADV runs long, and reset mid-advance.
    base = m_cum[0];
    for (int i = 1; i < 64; i++) send(0, base + 32'(i), 4'(i));
    drain(0);
    send(0, base, 4'd11);
    repeat (20) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    check("rst_ack_valid", 96'(av[0]), 96'(0));
    check("rst_data_ready", 96'(dr[0]), 96'(0));
    model_reset(0);
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ready", 96'(dr[0]), 96'(1));
    check("post_rst_drop", 96'(dcnt[0]), 96'(0));
    send(0, 32'd0, 4'd12);
    drain(0);
    check("post_rst_cum", 96'(last_cum[0]), 96'(32'd1));

    // Continuous ahead traffic to saturate the drop counter.
    rdy_bad = 0;
    @(posedge clk); #1;
    dv[0] = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      ds[0] = m_cum[0] + 32'd128 + 32'($urandom_range(0, 100000));
      dt[0] = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (!dr[0]) rdy_bad++;
      @(posedge clk); #1;
      model(0, ds[0], dt[0], cyc);
    end
    dv[0] = 1'b0;
    @(negedge clk);
    check("sat_ready_stalls", 96'(rdy_bad), 96'(0));
    check("sat_drop_cnt", 96'(dcnt[0]), 96'(16'hFFFF));
    check("sat_no_ack", 96'(av[0]), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_ack_generator.md
Name: rx_ack_generator

Overview:
- Receiver-side counterpart to the sender's incoming-ACK logic. Tracks arriving data sequence numbers in a per-flow receive bitmap and advances the cumulative ACK over contiguous received packets.
- For every accepted data packet, emits exactly one ACK descriptor: cumulative ACK, selective ACK (the triggering sequence number) and the echoed transmission id.
- Sits between the receive-path parser and the ACK packet builder.
- Single flow per instance.

Parameters:
- SEQ_W, 32: sequence number width (matches FLOW_SEQ_NUM_W).
- WIN_SIZE, 128: receive window in packets; power of two.
- TX_CNT_W, 4: transmission-id width (matches TX_CNT_W).
- PKT_TYPE_W, 4: packet type width.
- ACK_TYPE, 1: pkt_type value driven on ACK descriptors.
- INIT_SEQ, 0: cumulative ACK value after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_valid  in  1  data packet descriptor valid.
- data_ready  out  1  block can accept a descriptor.
- data_seq  in  SEQ_W  sequence number of the arriving data packet.
- data_tx_id  in  TX_CNT_W  transmission id of the arriving data packet.
- ack_valid  out  1  ACK descriptor valid.
- ack_ready  in  1  downstream accepts the ACK descriptor.
- ack_pkt_type  out  PKT_TYPE_W  always ACK_TYPE.
- ack_cumulative  out  SEQ_W  next expected sequence number.
- ack_selective  out  SEQ_W  sequence number that triggered this ACK.
- ack_tx_id  out  TX_CNT_W  echoed data_tx_id.
- ack_dup  out  1  triggering packet was already received or below the cumulative ACK.
- drop_cnt  out  16  count of packets dropped as beyond the window; saturating.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cum=INIT_SEQ, bitmap=0, drop_cnt=0.
  - ack_valid=0; all ack_* fields=0 except ack_pkt_type=ACK_TYPE.
  - data_ready=0 while in reset.
  - Assertion mid-operation discards any pending ACK and any advance in progress.
- State IDLE:
  - data_ready=1, ack_valid=0.
  - Handshake occurs when data_valid & data_ready at a rising edge.
- Classification on handshake, using diff = data_seq - cum modulo 2^SEQ_W (unsigned):
  - diff < WIN_SIZE, in window:
    - ack_dup = bitmap[diff] before the set.
    - Set bitmap[diff]; latch data_seq and data_tx_id into the ACK fields; go to ADV.
  - diff >= 2^(SEQ_W-1), old:
    - ack_dup=1; latch fields; go directly to SEND. Bitmap untouched.
  - Otherwise, ahead of window:
    - Drop the packet. drop_cnt += 1, saturating at 0xFFFF.
    - Stay in IDLE; no ACK is produced.
- State ADV:
  - data_ready=0.
  - Each cycle with bitmap[0]=1: bitmap shifts right by 1 (MSB filled with 0) and cum += 1, wrapping modulo 2^SEQ_W.
  - A cycle with bitmap[0]=0 transitions to SEND.
  - Advancing k packets occupies k shifting cycles plus one exit cycle.
- State SEND:
  - ack_valid=1, data_ready=0.
  - ack_cumulative = cum, captured on entry to SEND. All ack_* fields are stable while ack_valid=1 && ack_ready=0.
  - On ack_valid & ack_ready, go to IDLE.
  - No back-to-back accept in the same cycle; data_ready rises the cycle after the ACK handshake.
- Latency, with cycle 0 = data handshake:
  - In window: ack_valid asserts in cycle k+2, where k = number of packets advanced.
  - Old packet: ack_valid asserts in cycle 1.
- Exactly one ACK per accepted non-dropped packet. Order is preserved; one packet is in flight at a time.
- Wrap-around:
  - All comparisons use the modular difference.
  - cum crossing 2^SEQ_W-1 → 0 must advance correctly.
- Bitmap bit i always represents sequence number cum+i.

Decomposition:
- Shared package/header entries:
  - The ACK_TYPE encoding.
  - The state encoding (IDLE, ADV, SEND).
  - SEQ_W, TX_CNT_W and WIN_SIZE, taken from the existing flow defines.
- One natural sub-module, rx_seq_classify: combinational modular-difference classifier.
  - Inputs: data_seq, cum. Outputs: in_window, old, ahead, and the bitmap index (log2(WIN_SIZE) bits).
  - It is reusable by the sender-side window checks.
- The rest (bitmap register, advance FSM, output register set) lives in the top module.

Test Plan:
- In-order: reset, INIT_SEQ=0; send seq 0, tx_id 2 with ack_ready=1.
  - → ack_valid in cycle 3 with cum=1, sel=0, tx_id=2, dup=0.
- Reorder: send 2, then 1, then 0.
  - → ACKs in order: (cum 0, sel 2), (cum 0, sel 1), (cum 3, sel 0).
  - The third ACK asserts in cycle 5 after its handshake (k=3).
- Duplicate and old: after cum=3, send seq 1.
  - → ack_valid in cycle 1, cum=3, sel=1, dup=1.
  - Then send seq 5 twice → second ACK has dup=1, cum=3.
- Ahead drop: cum=3, send seq 3+128=131.
  - → no ACK, data_ready stays 1, drop_cnt=1.
  - Send 0xFFFF+ further drops → drop_cnt saturates at 0xFFFF.
- Backpressure and wrap: INIT_SEQ=0xFFFFFFFE; send 0xFFFFFFFE, then 0xFFFFFFFF, with ack_ready=0 for 10 cycles each.
  - → fields stay stable and data_ready stays 0 while held.
  - Final ACK reports cum=0x00000000.
- Reset mid-ADV: accept 64 contiguous-completing packets, then assert rst_n=0 during ADV.
  - → ack_valid=0 immediately; after release cum=INIT_SEQ, bitmap clear, data_ready=1.
